// File: rtl/sha3_pkg.sv
// Shared constants and state type for the SHA3 message padder.
package sha3_pkg;

  localparam int unsigned SHA3_RATE_BYTES = 136;
  localparam int unsigned SHA3_RATE_BITS  = SHA3_RATE_BYTES * 8;
  localparam logic [7:0]  SHA3_DOMAIN     = 8'h06;
  localparam logic [7:0]  SHA3_PAD_END    = 8'h80;
  localparam logic [7:0]  SHA3_LAST_IDX   = 8'(SHA3_RATE_BYTES - 1);

  typedef enum logic [1:0] {
    StFill,
    StOut,
    StPadOut
  } padder_state_t;

endpackage

// File: rtl/sha3_padder_if.sv
// Byte input stream plus rate-block output handshake of the SHA3 padder.
// master: the environment (byte source and block sink); slave: the padder.
interface sha3_padder_if
  import sha3_pkg::*;
();

  logic                      in_valid;
  logic                      in_ready;
  logic [7:0]                in_data;
  logic                      in_last;
  logic                      in_empty;
  logic                      blk_valid;
  logic                      blk_ready;
  logic [SHA3_RATE_BITS-1:0] blk_data;
  logic                      blk_last;

  modport master (
    output in_valid, in_data, in_last, in_empty, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_empty, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last
  );

endinterface

// File: rtl/sha3_padder.sv
// SHA3 byte-stream padder: collects message bytes into a 1088-bit rate block,
// applies 0x06..0x80 domain padding and hands blocks to the permutation core.
// Optional feature macro: SHA3_PADDER_LEN_EN adds the msg_len byte counter output.
module sha3_padder
  import sha3_pkg::*;
(
  input logic          clk,
  input logic          rst,
  sha3_padder_if.slave bus
`ifdef SHA3_PADDER_LEN_EN
  ,
  output logic [63:0]  msg_len
`endif
);

  padder_state_t             state_q, state_d;
  logic [SHA3_RATE_BITS-1:0] buf_q, buf_d;
  logic [7:0]                idx_q, idx_d;
  logic                      last_q, last_d;
  logic                      pend_q, pend_d;

  logic       in_ready;
  logic       blk_valid;
  logic       data_beat;
  logic       pad_here;
  logic [7:0] lane;

  // Next-state, byte-lane write decoder and handshake outputs.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    idx_d     = idx_q;
    last_d    = last_q;
    pend_d    = pend_q;
    in_ready  = 1'b0;
    blk_valid = 1'b0;
    lane      = 8'h00;
    data_beat = bus.in_valid & ~bus.in_empty;
    // A last beat closes the padding in this block unless its data fills byte 135.
    pad_here  = bus.in_last & (bus.in_empty | (idx_q != SHA3_LAST_IDX));

    unique case (state_q)
      StFill: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          for (int i = 0; i < SHA3_RATE_BYTES; i++) begin
            lane = buf_q[8*i +: 8];
            if (8'(i) == idx_q) begin
              if (!bus.in_empty)   lane = bus.in_data;
              else if (bus.in_last) lane = SHA3_DOMAIN;
            end
            if (data_beat && pad_here && (8'(i) == idx_q + 8'd1)) lane = SHA3_DOMAIN;
            if (pad_here && (8'(i) == SHA3_LAST_IDX)) lane = lane | SHA3_PAD_END;
            buf_d[8*i +: 8] = lane;
          end
          if (bus.in_last) begin
            state_d = StOut;
            last_d  = pad_here;
            pend_d  = ~pad_here;
          end else if (data_beat) begin
            if (idx_q == SHA3_LAST_IDX) begin
              state_d = StOut;
              last_d  = 1'b0;
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end
        end
      end
      StOut: begin
        blk_valid = 1'b1;
        if (bus.blk_ready) begin
          buf_d = '0;
          idx_d = 8'd0;
          if (pend_q) begin
            // Message ended exactly on a block boundary: emit a pad-only block.
            buf_d[7:0]                       = SHA3_DOMAIN;
            buf_d[SHA3_RATE_BITS-1 -: 8]     = SHA3_PAD_END;
            last_d                           = 1'b1;
            state_d                          = StPadOut;
          end else begin
            last_d  = 1'b0;
            state_d = StFill;
          end
        end
      end
      StPadOut: begin
        blk_valid = 1'b1;
        if (bus.blk_ready) begin
          buf_d   = '0;
          last_d  = 1'b0;
          pend_d  = 1'b0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // State, buffer and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFill;
      buf_q   <= '0;
      idx_q   <= 8'd0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.blk_valid = blk_valid;
  assign bus.blk_data  = buf_q;
  assign bus.blk_last  = last_q;

`ifdef SHA3_PADDER_LEN_EN
  logic [63:0] len_cnt_q, len_cnt_d;
  logic [63:0] msg_len_q, msg_len_d;

  // Count data beats of the current message; publish on the final block handshake.
  always_comb begin
    len_cnt_d = len_cnt_q;
    msg_len_d = msg_len_q;
    if (in_ready && data_beat) len_cnt_d = len_cnt_q + 64'd1;
    if (blk_valid && bus.blk_ready && last_q) begin
      msg_len_d = len_cnt_q;
      len_cnt_d = 64'd0;
    end
  end

  // Length counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_cnt_q <= 64'd0;
      msg_len_q <= 64'd0;
    end else begin
      len_cnt_q <= len_cnt_d;
      msg_len_q <= msg_len_d;
    end
  end

  assign msg_len = msg_len_q;
`endif

endmodule

// File: tb/tb_sha3_padder.sv
// Self-checking bench for sha3_padder: queue-based padding model, per-cycle
// output compare, directed test-plan cases and randomized messages.
module tb_sha3_padder;
  import sha3_pkg::*;

  typedef logic [SHA3_RATE_BITS-1:0] blk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha3_padder_if bus ();

`ifdef SHA3_PADDER_LEN_EN
  logic [63:0] msg_len;
`endif

  sha3_padder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SHA3_PADDER_LEN_EN
    ,
    .msg_len (msg_len)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  blk_t            exp_data[$];
  bit              exp_last[$];
  longint unsigned exp_len_q[$];
  longint unsigned exp_len = 0;
  int              ready_mode = 1;  // 0 random, 1 always ready, 2 stalled

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_blk(input string name, input blk_t act, input blk_t req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      for (int i = 0; i < SHA3_RATE_BYTES; i++) begin
        if (act[8*i +: 8] !== req[8*i +: 8]) begin
          $display("FAIL %s: byte %0d got %h expected %h", name, i, act[8*i +: 8], req[8*i +: 8]);
          break;
        end
      end
    end
  endtask

  // Pad the whole message as a byte stream, then cut it into rate blocks.
  task automatic model_build(input logic [7:0] msg[$], output blk_t blks[$], output bit lasts[$]);
    logic [7:0] s[$];
    int         n;
    int         p;
    int         nb;
    blk_t       b;
    s  = msg;
    n  = msg.size();
    p  = SHA3_RATE_BYTES - (n % SHA3_RATE_BYTES);
    if (p == 1) begin
      s.push_back(8'h86);
    end else begin
      s.push_back(8'h06);
      repeat (p - 2) s.push_back(8'h00);
      s.push_back(8'h80);
    end
    nb = s.size() / SHA3_RATE_BYTES;
    blks.delete();
    lasts.delete();
    for (int k = 0; k < nb; k++) begin
      b = '0;
      for (int j = 0; j < SHA3_RATE_BYTES; j++) b[8*j +: 8] = s[k*SHA3_RATE_BYTES + j];
      blks.push_back(b);
      lasts.push_back(k == nb - 1);
    end
  endtask

  task automatic model_push(input logic [7:0] msg[$]);
    blk_t blks[$];
    bit   lasts[$];
    model_build(msg, blks, lasts);
    foreach (blks[k]) begin
      exp_data.push_back(blks[k]);
      exp_last.push_back(lasts[k]);
      exp_len_q.push_back(longint'(msg.size()));
    end
  endtask

  // Block sink ready generator.
  initial begin
    bus.blk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.blk_ready = ($urandom_range(0, 3) != 0);
        1:       bus.blk_ready = 1'b1;
        default: bus.blk_ready = 1'b0;
      endcase
    end
  end

  // Per-cycle output compare against the model queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("in_ready_vs_blk_valid", longint'(bus.in_ready), longint'(!bus.blk_valid));
`ifdef SHA3_PADDER_LEN_EN
        check("msg_len", msg_len, exp_len);
`endif
        if (bus.blk_valid) begin
          if (exp_data.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_block: got blk_valid=1 expected no block");
          end else begin
            check_blk("blk_data", bus.blk_data, exp_data[0]);
            check("blk_last", longint'(bus.blk_last), longint'(exp_last[0]));
            if (bus.blk_ready) begin
              if (exp_last[0]) exp_len = exp_len_q[0];
              void'(exp_data.pop_front());
              void'(exp_last.pop_front());
              void'(exp_len_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input bit last, input bit empty, input bit gaps);
    int  t;
    bit  acc;
    t = 0;
    while (gaps && ($urandom_range(0, 3) == 0)) begin
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_empty = empty;
    forever begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 2000) begin
        $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected acceptance", t);
        $fatal(1, "input stalled");
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] msg[$], input bit empty_end, input bit gaps);
    int n;
    n = msg.size();
    model_push(msg);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 15) == 0)) send_beat(8'hFF, 1'b0, 1'b1, gaps);
      send_beat(msg[i], (i == n - 1) && !empty_end, 1'b0, gaps);
    end
    if (empty_end || n == 0) send_beat(8'h00, 1'b1, 1'b1, gaps);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_data.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    n_checks++;
    if (exp_data.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d blocks outstanding expected 0", exp_data.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, longint'(bus.in_ready), 1);
    check({tag, "_blk_valid"}, longint'(bus.blk_valid), 0);
    check({tag, "_blk_last"}, longint'(bus.blk_last), 0);
    check_blk({tag, "_blk_data"}, bus.blk_data, '0);
`ifdef SHA3_PADDER_LEN_EN
    check({tag, "_msg_len"}, msg_len, 0);
`endif
  endtask

  initial begin
    logic [7:0] abc[$];
    logic [7:0] m[$];
    blk_t       blks[$];
    bit         lasts[$];
    blk_t       saved;
    int         n;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
    abc = '{8'h61, 8'h62, 8'h63};

    // Hand-computed pins on the model itself.
    model_build(abc, blks, lasts);
    check("pin_abc_nblk", blks.size(), 1);
    check("pin_abc_b2", blks[0][23:16], 8'h63);
    check("pin_abc_b3", blks[0][31:24], 8'h06);
    check("pin_abc_b135", blks[0][1087:1080], 8'h80);
    m.delete();
    repeat (135) m.push_back(8'hAA);
    model_build(m, blks, lasts);
    check("pin_135_b135", blks[0][1087:1080], 8'h86);
    m.push_back(8'hAA);
    model_build(m, blks, lasts);
    check("pin_136_nblk", blks.size(), 2);
    check("pin_136_last0", longint'(lasts[0]), 0);
    check("pin_136_b1_0", blks[1][7:0], 8'h06);

    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed test-plan messages.
    ready_mode = 1;
    send_msg(abc, 1'b0, 1'b0);
    m.delete();
    send_msg(m, 1'b1, 1'b0);
    m.delete();
    repeat (135) m.push_back(8'hAA);
    send_msg(m, 1'b0, 1'b0);
    m.delete();
    repeat (136) m.push_back(8'h55);
    send_msg(m, 1'b0, 1'b0);
    wait_drain();
`ifdef SHA3_PADDER_LEN_EN
    check("msg_len_136", msg_len, 136);
`endif

    // Backpressure: block held for 10 cycles, taken on first ready cycle.
    ready_mode = 2;
    send_msg(abc, 1'b0, 1'b0);
    saved = bus.blk_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_valid", longint'(bus.blk_valid), 1);
      check("bp_in_ready", longint'(bus.in_ready), 0);
      check_blk("bp_stable", bus.blk_data, saved);
    end
    ready_mode = 1;
    @(negedge clk);
    check("bp_handshake", longint'(bus.blk_valid & bus.blk_ready), 1);
    @(negedge clk);
    check("bp_released", longint'(bus.blk_valid), 0);
    check("bp_in_ready_back", longint'(bus.in_ready), 1);
    wait_drain();

    // Reset mid-message discards the partial block.
    for (int i = 0; i < 50; i++) send_beat(8'($urandom), 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    exp_len = 0;
    reset_checks("midreset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_msg(abc, 1'b0, 1'b0);
    wait_drain();

    // Randomized messages with random gaps and backpressure.
    ready_mode = 0;
    for (int k = 0; k < 24; k++) begin
      m.delete();
      case ($urandom_range(0, 3))
        0:       n = 136 * $urandom_range(0, 2);
        1:       n = 136 * $urandom_range(1, 2) - 1;
        default: n = $urandom_range(0, 300);
      endcase
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      send_msg(m, (n % 136 == 0) && ($urandom_range(0, 1) == 1), 1'b1);
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
